// File: rtl/snake_pkg.sv
// Shared codes for the snake engine: direction and game-state encodings,
// plus the reverse-direction helper used by the direction filter.
package snake_pkg;

    typedef enum logic [2:0] {
        DIR_IDLE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    localparam logic [1:0] GS_PLAY      = 2'b01;
    localparam logic [1:0] GS_GAME_OVER = 2'b11;

    function automatic dir_e opposite(input dir_e d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/snake_cell_hit.sv
// Combinational test of whether (x_pos, y_pos) lies inside the CELL x CELL box
// whose top-left corner is (cell_x, cell_y).
module snake_cell_hit #(
    parameter int BIT  = 10,
    parameter int CELL = 5
) (
    input  logic [BIT-1:0] cell_x,
    input  logic [BIT-1:0] cell_y,
    input  logic [BIT-1:0] x_pos,
    input  logic [BIT-1:0] y_pos,
    output logic           hit
);

    localparam logic [BIT:0] CELL_EXT = (BIT+1)'(CELL);

    // Far edges carry an extra bit so a cell at the top of the range cannot wrap.
    logic [BIT:0] x_end, y_end;

    assign x_end = {1'b0, cell_x} + CELL_EXT;
    assign y_end = {1'b0, cell_y} + CELL_EXT;

    assign hit = (x_pos >= cell_x) && ({1'b0, x_pos} < x_end) &&
                 (y_pos >= cell_y) && ({1'b0, y_pos} < y_end);

endmodule

// File: rtl/snake_engine.sv
// Snake body engine: head plus shift-register body, tick-driven movement,
// growth, wall/self collision pulses and per-pixel head/body flags.
module snake_engine
    import snake_pkg::*;
#(
    parameter int         BIT       = 10,
    parameter int         CELL      = 5,
    parameter int         MAX_LEN   = 16,
    parameter int         INIT_LEN  = 3,
    parameter int         X_START   = 320,
    parameter int         Y_START   = 240,
    parameter int         X_MAX     = 640,
    parameter int         Y_MAX     = 480,
    parameter logic [2:0] SNAKE_RGB = 3'b010
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         update,
    input  logic [2:0]                   direction,
    input  logic [1:0]                   game_state,
    input  logic                         grow,
    input  logic [BIT-1:0]               x_pos,
    input  logic [BIT-1:0]               y_pos,
    output logic [BIT-1:0]               head_x,
    output logic [BIT-1:0]               head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         snake_head_active,
    output logic                         snake_body_active,
    output logic                         wall_hit,
    output logic                         self_hit,
    output logic [2:0]                   rgb
);

    localparam int             LW     = $clog2(MAX_LEN+1);
    localparam logic [BIT-1:0] CELL_B = BIT'(CELL);
    localparam logic [BIT-1:0] X_LAST = BIT'(X_MAX - CELL);
    localparam logic [BIT-1:0] Y_LAST = BIT'(Y_MAX - CELL);

    logic [BIT-1:0]              head_x_q, head_x_d, head_y_q, head_y_d;
    logic [MAX_LEN-1:0][BIT-1:0] body_x_q, body_x_d, body_y_q, body_y_d;
    logic [LW-1:0]               len_q, len_d;
    dir_e                        dir_q, dir_d, dir_f;
    logic                        grow_pend_q, grow_pend_d;
    logic                        wall_hit_q, wall_hit_d, self_hit_q, self_hit_d;

    logic [BIT-1:0]     cand_x, cand_y;
    logic               wall, grow_now, grow_ok, move, restart, head_pix;
    logic [MAX_LEN-1:0] body_act, body_pix, self_cmp, self_vec;

    // Filtered direction, candidate head and wall test all use this clock's filter result.
    always_comb begin
        dir_f = dir_q;
        if (direction inside {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} &&
            !(dir_q != DIR_IDLE && direction == opposite(dir_q)))
            dir_f = dir_e'(direction);
        grow_now = grow_pend_q | grow;
        grow_ok  = grow_now && (int'(len_q) < MAX_LEN);
        move     = update && (game_state == GS_PLAY) && (dir_f != DIR_IDLE);
        restart  = reset || (game_state == GS_GAME_OVER);
        cand_x   = head_x_q;
        cand_y   = head_y_q;
        wall     = 1'b0;
        case (dir_f)
            DIR_UP:    begin cand_y = head_y_q - CELL_B; wall = head_y_q < CELL_B;  end
            DIR_DOWN:  begin cand_y = head_y_q + CELL_B; wall = head_y_q >= Y_LAST; end
            DIR_LEFT:  begin cand_x = head_x_q - CELL_B; wall = head_x_q < CELL_B;  end
            DIR_RIGHT: begin cand_x = head_x_q + CELL_B; wall = head_x_q >= X_LAST; end
            default: ;
        endcase
    end

    // The tail cell is free to enter unless this move also grows the snake.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            body_act[i] = i < int'(len_q);
            self_vec[i] = body_act[i] && self_cmp[i] &&
                          !((i == int'(len_q) - 1) && !grow_ok);
        end
    end

    always_comb begin
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        body_x_d    = body_x_q;
        body_y_d    = body_y_q;
        len_d       = len_q;
        dir_d       = dir_f;
        grow_pend_d = grow_now;
        wall_hit_d  = 1'b0;
        self_hit_d  = 1'b0;
        if (move) begin
            if (wall) begin
                wall_hit_d = 1'b1;
            end else if (|self_vec) begin
                self_hit_d = 1'b1;
            end else begin
                head_x_d    = cand_x;
                head_y_d    = cand_y;
                body_x_d    = {body_x_q[MAX_LEN-2:0], head_x_q};
                body_y_d    = {body_y_q[MAX_LEN-2:0], head_y_q};
                grow_pend_d = 1'b0;
                if (grow_ok)
                    len_d = len_q + LW'(1);
            end
        end
        if (restart) begin
            head_x_d = BIT'(X_START);
            head_y_d = BIT'(Y_START);
            for (int i = 0; i < MAX_LEN; i++) begin
                body_x_d[i] = BIT'(X_START - (i + 1) * CELL);
                body_y_d[i] = BIT'(Y_START);
            end
            len_d       = LW'(INIT_LEN);
            dir_d       = DIR_IDLE;
            grow_pend_d = 1'b0;
            wall_hit_d  = 1'b0;
            self_hit_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        head_x_q    <= head_x_d;
        head_y_q    <= head_y_d;
        body_x_q    <= body_x_d;
        body_y_q    <= body_y_d;
        len_q       <= len_d;
        dir_q       <= dir_d;
        grow_pend_q <= grow_pend_d;
        wall_hit_q  <= wall_hit_d;
        self_hit_q  <= self_hit_d;
    end

    snake_cell_hit #(.BIT(BIT), .CELL(CELL)) u_head_hit (
        .cell_x(head_x_q), .cell_y(head_y_q), .x_pos(x_pos), .y_pos(y_pos), .hit(head_pix)
    );

    // Cells are CELL-aligned, so "candidate inside body cell" is an exact equality test.
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_body
        snake_cell_hit #(.BIT(BIT), .CELL(CELL)) u_pix_hit (
            .cell_x(body_x_q[i]), .cell_y(body_y_q[i]), .x_pos(x_pos), .y_pos(y_pos),
            .hit(body_pix[i])
        );
        snake_cell_hit #(.BIT(BIT), .CELL(CELL)) u_self_hit (
            .cell_x(body_x_q[i]), .cell_y(body_y_q[i]), .x_pos(cand_x), .y_pos(cand_y),
            .hit(self_cmp[i])
        );
    end

    assign head_x            = head_x_q;
    assign head_y            = head_y_q;
    assign length            = len_q;
    assign snake_head_active = head_pix;
    assign snake_body_active = |(body_pix & body_act);
    assign wall_hit          = wall_hit_q;
    assign self_hit          = self_hit_q;
    assign rgb               = SNAKE_RGB;

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: directed scenarios plus a randomized run
// against a queue-based behavioural model of the snake.
module tb_snake_engine;

    localparam int BIT = 10, CELL = 5, MAX_LEN = 16, INIT_LEN = 3;
    localparam int X_START = 320, Y_START = 240, X_MAX = 640, Y_MAX = 480;
    localparam int LW = $clog2(MAX_LEN+1);
    localparam logic [2:0] IDLE = 3'd0, UP = 3'd1, DOWN = 3'd2, LEFT = 3'd3, RIGHT = 3'd4;
    localparam logic [1:0] PLAY = 2'b01, OVER = 2'b11;

    logic           clk = 1'b0;
    logic           reset, update, grow;
    logic [2:0]     direction;
    logic [1:0]     game_state;
    logic [BIT-1:0] x_pos, y_pos;
    logic [BIT-1:0] head_x, head_y;
    logic [LW-1:0]  length;
    logic           snake_head_active, snake_body_active, wall_hit, self_hit;
    logic [2:0]     rgb;

    int checks = 0;
    int errors = 0;

    snake_engine dut (
        .clk(clk), .reset(reset), .update(update), .direction(direction),
        .game_state(game_state), .grow(grow), .x_pos(x_pos), .y_pos(y_pos),
        .head_x(head_x), .head_y(head_y), .length(length),
        .snake_head_active(snake_head_active), .snake_body_active(snake_body_active),
        .wall_hit(wall_hit), .self_hit(self_hit), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // Reference model: head point plus a queue of body points, newest first.
    int hx, hy, mlen, mdir;
    bit mgp, mwh, msh;
    int bxq[$], byq[$];

    function automatic int rev(int d);
        case (d)
            1: return 2;
            2: return 1;
            3: return 4;
            4: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic void m_init();
        hx = X_START; hy = Y_START;
        bxq.delete(); byq.delete();
        for (int k = 0; k < MAX_LEN; k++) begin
            bxq.push_back(X_START - (k + 1) * CELL);
            byq.push_back(Y_START);
        end
        mlen = INIT_LEN; mdir = 0; mgp = 0; mwh = 0; msh = 0;
    endfunction

    function automatic void m_step();
        int  nx, ny;
        bit  g, grows;
        mwh = 0; msh = 0;
        if (reset || game_state == OVER) begin
            m_init();
            return;
        end
        if (direction >= 1 && direction <= 4 && !(mdir != 0 && int'(direction) == rev(mdir)))
            mdir = int'(direction);
        g = mgp || grow;
        mgp = g;
        if (update && game_state == PLAY && mdir != 0) begin
            nx = hx; ny = hy;
            case (mdir)
                1: ny -= CELL;
                2: ny += CELL;
                3: nx -= CELL;
                default: nx += CELL;
            endcase
            grows = g && (mlen < MAX_LEN);
            if (nx < 0 || ny < 0 || nx + CELL > X_MAX || ny + CELL > Y_MAX) begin
                mwh = 1;
            end else begin
                for (int k = 0; k < mlen; k++)
                    if (!(k == mlen - 1 && !grows) && bxq[k] == nx && byq[k] == ny) msh = 1;
                if (!msh) begin
                    bxq.push_front(hx); byq.push_front(hy);
                    void'(bxq.pop_back()); void'(byq.pop_back());
                    hx = nx; hy = ny;
                    if (grows) mlen++;
                    mgp = 0;
                end
            end
        end
    endfunction

    function automatic bit in_cell(int cx, int cy, int x, int y);
        return x >= cx && x < cx + CELL && y >= cy && y < cy + CELL;
    endfunction

    function automatic bit m_body(int x, int y);
        for (int k = 0; k < mlen; k++)
            if (in_cell(bxq[k], byq[k], x, y)) return 1;
        return 0;
    endfunction

    task automatic tick(input logic upd, input logic [2:0] d, input logic g);
        update = upd; direction = d; grow = g;
        m_step();
        @(posedge clk); #1;
        update = 1'b0; grow = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_step();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({head_x, head_y, length, wall_hit, self_hit} !== {10'd320, 10'd240, 5'd3, 2'b00}) begin
            errors++;
            $display("FAIL reset_state: got %0d,%0d len %0d w%0b s%0b want 320,240 len 3 w0 s0",
                     head_x, head_y, length, wall_hit, self_hit);
        end
        checks++;
        if (rgb !== 3'b010) begin
            errors++; $display("FAIL rgb: got %b want 010", rgb);
        end
        tick(1, RIGHT, 0);
        tick(1, RIGHT, 0);
        // reset wins over a coincident update and grow
        update = 1'b1; grow = 1'b1; direction = RIGHT;
        do_reset();
        update = 1'b0; grow = 1'b0;
        checks++;
        if ({head_x, head_y, length} !== {10'd320, 10'd240, 5'd3}) begin
            errors++;
            $display("FAIL reset_mid_move: got %0d,%0d len %0d want 320,240 len 3", head_x, head_y, length);
        end
    endtask

    task automatic test_move_right();
        do_reset();
        for (int n = 0; n < 3; n++) tick(1, RIGHT, 0);
        checks++;
        if ({head_x, head_y, length, wall_hit, self_hit} !== {10'd335, 10'd240, 5'd3, 2'b00}) begin
            errors++;
            $display("FAIL move_right: got %0d,%0d len %0d w%0b s%0b want 335,240 len 3 w0 s0",
                     head_x, head_y, length, wall_hit, self_hit);
        end
        for (int k = 0; k < 4; k++) begin
            x_pos = BIT'(332 - 5 * k); y_pos = 10'd242; #1;
            checks++;
            if (snake_body_active !== (k < 3)) begin
                errors++;
                $display("FAIL body_after_move k=%0d: got %0b want %0b", k, snake_body_active, k < 3);
            end
        end
    endtask

    task automatic test_reverse();
        do_reset();
        tick(1, RIGHT, 0);
        tick(1, LEFT, 0);
        checks++;
        if ({head_x, head_y} !== {10'd330, 10'd240}) begin
            errors++; $display("FAIL reverse_ignored: got %0d,%0d want 330,240", head_x, head_y);
        end
        tick(1, UP, 0);
        checks++;
        if ({head_x, head_y} !== {10'd330, 10'd235}) begin
            errors++; $display("FAIL turn_up: got %0d,%0d want 330,235", head_x, head_y);
        end
        tick(1, IDLE, 0);
        checks++;
        if ({head_x, head_y} !== {10'd330, 10'd230}) begin
            errors++; $display("FAIL idle_ignored: got %0d,%0d want 330,230", head_x, head_y);
        end
    endtask

    task automatic test_grow();
        do_reset();
        tick(0, RIGHT, 1);
        tick(1, RIGHT, 0);
        checks++;
        if ({head_x, length} !== {10'd325, 5'd4}) begin
            errors++; $display("FAIL grow_first: got x %0d len %0d want x 325 len 4", head_x, length);
        end
        x_pos = 10'd305; y_pos = 10'd240; #1;
        checks++;
        if (snake_body_active !== 1'b1) begin
            errors++; $display("FAIL grow_new_tail: got %0b want 1", snake_body_active);
        end
        x_pos = 10'd300; #1;
        checks++;
        if (snake_body_active !== 1'b0) begin
            errors++; $display("FAIL grow_beyond_tail: got %0b want 0", snake_body_active);
        end
        tick(1, RIGHT, 0);
        checks++;
        if ({head_x, length} !== {10'd330, 5'd4}) begin
            errors++; $display("FAIL grow_once: got x %0d len %0d want x 330 len 4", head_x, length);
        end
        for (int n = 0; n < 15; n++) tick(1, RIGHT, 1);
        checks++;
        if ({head_x, length} !== {10'd405, 5'd16}) begin
            errors++; $display("FAIL grow_saturate: got x %0d len %0d want x 405 len 16", head_x, length);
        end
    endtask

    task automatic test_wall();
        do_reset();
        for (int n = 0; n < 63; n++) tick(1, RIGHT, 0);
        checks++;
        if ({head_x, wall_hit} !== {10'd635, 1'b0}) begin
            errors++; $display("FAIL wall_approach: got x %0d w%0b want x 635 w0", head_x, wall_hit);
        end
        tick(1, RIGHT, 0);
        checks++;
        if ({head_x, head_y, wall_hit, self_hit} !== {10'd635, 10'd240, 2'b10}) begin
            errors++;
            $display("FAIL wall_pulse: got %0d,%0d w%0b s%0b want 635,240 w1 s0", head_x, head_y, wall_hit, self_hit);
        end
        tick(0, RIGHT, 0);
        checks++;
        if (wall_hit !== 1'b0) begin
            errors++; $display("FAIL wall_pulse_width: got %0b want 0", wall_hit);
        end
        game_state = OVER;
        tick(0, RIGHT, 0);
        checks++;
        if ({head_x, head_y, length} !== {10'd320, 10'd240, 5'd3}) begin
            errors++; $display("FAIL game_over: got %0d,%0d len %0d want 320,240 len 3", head_x, head_y, length);
        end
        tick(1, RIGHT, 1);
        checks++;
        if ({head_x, length} !== {10'd320, 5'd3}) begin
            errors++; $display("FAIL game_over_hold: got x %0d len %0d want x 320 len 3", head_x, length);
        end
        game_state = PLAY;
    endtask

    task automatic test_self();
        do_reset();
        tick(1, RIGHT, 1);
        tick(1, RIGHT, 1);
        tick(1, UP, 0);
        tick(1, LEFT, 0);
        tick(1, DOWN, 0);
        checks++;
        if ({head_x, head_y, length, wall_hit, self_hit} !== {10'd325, 10'd235, 5'd5, 2'b01}) begin
            errors++;
            $display("FAIL self_pulse: got %0d,%0d len %0d w%0b s%0b want 325,235 len 5 w0 s1",
                     head_x, head_y, length, wall_hit, self_hit);
        end
        tick(0, DOWN, 0);
        checks++;
        if (self_hit !== 1'b0) begin
            errors++; $display("FAIL self_pulse_width: got %0b want 0", self_hit);
        end
        // 2x2 loop: head plus three body cells chase the vacating tail
        do_reset();
        tick(1, UP, 0);
        tick(1, LEFT, 0);
        tick(1, DOWN, 0);
        tick(1, RIGHT, 0);
        checks++;
        if ({head_x, head_y, self_hit} !== {10'd320, 10'd240, 1'b0}) begin
            errors++; $display("FAIL tail_vacate: got %0d,%0d s%0b want 320,240 s0", head_x, head_y, self_hit);
        end
        tick(1, UP, 1);
        checks++;
        if ({head_x, head_y, length, self_hit} !== {10'd320, 10'd240, 5'd3, 1'b1}) begin
            errors++;
            $display("FAIL tail_grow_hit: got %0d,%0d len %0d s%0b want 320,240 len 3 s1", head_x, head_y, length, self_hit);
        end
    endtask

    task automatic test_pixel();
        do_reset();
        y_pos = 10'd240;
        for (int x = 298; x <= 326; x++) begin
            x_pos = BIT'(x); #1;
            checks++;
            if ({snake_head_active, snake_body_active} !== {x >= 320 && x < 325, x >= 305 && x < 320}) begin
                errors++;
                $display("FAIL pixel_sweep x=%0d: got h%0b b%0b want h%0b b%0b", x,
                         snake_head_active, snake_body_active, x >= 320 && x < 325, x >= 305 && x < 320);
            end
        end
        x_pos = 10'd322;
        for (int y = 239; y <= 245; y++) begin
            y_pos = BIT'(y); #1;
            checks++;
            if (snake_head_active !== (y >= 240 && y < 245)) begin
                errors++;
                $display("FAIL pixel_y y=%0d: got %0b want %0b", y, snake_head_active, y >= 240 && y < 245);
            end
        end
    endtask

    task automatic test_random();
        int px, py, pick;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            pick  = $urandom_range(0, 99);
            game_state = (pick < 86) ? PLAY : (pick < 98) ? 2'(pick[0] ? 2'b00 : 2'b10) : OVER;
            if ($urandom_range(0, 4) == 0) direction = 3'($urandom_range(0, 7));
            update = ($urandom_range(0, 2) == 0);
            grow   = ($urandom_range(0, 9) == 0);
            m_step();
            @(posedge clk); #1;
            checks++;
            if ({head_x, head_y, length, wall_hit, self_hit} !== {BIT'(hx), BIT'(hy), LW'(mlen), mwh, msh}) begin
                errors++;
                $display("FAIL random_state n=%0d: got %0d,%0d len %0d w%0b s%0b want %0d,%0d len %0d w%0b s%0b",
                         n, head_x, head_y, length, wall_hit, self_hit, hx, hy, mlen, mwh, msh);
            end
            pick = $urandom_range(0, MAX_LEN);
            px = (pick == MAX_LEN) ? hx : bxq[pick];
            py = (pick == MAX_LEN) ? hy : byq[pick];
            x_pos = BIT'(px + int'($urandom_range(0, CELL + 1)) - 1);
            y_pos = BIT'(py + int'($urandom_range(0, CELL + 1)) - 1);
            #1;
            checks++;
            if ({snake_head_active, snake_body_active} !==
                {in_cell(hx, hy, int'(x_pos), int'(y_pos)), m_body(int'(x_pos), int'(y_pos))}) begin
                errors++;
                $display("FAIL random_pixel n=%0d at %0d,%0d: got h%0b b%0b want h%0b b%0b", n, x_pos, y_pos,
                         snake_head_active, snake_body_active,
                         in_cell(hx, hy, int'(x_pos), int'(y_pos)), m_body(int'(x_pos), int'(y_pos)));
            end
        end
        reset = 1'b0; update = 1'b0; grow = 1'b0; game_state = PLAY;
    endtask

    initial begin
        reset = 1'b1; update = 1'b0; grow = 1'b0; direction = IDLE;
        game_state = PLAY; x_pos = '0; y_pos = '0;
        m_init();
        #1;
        test_reset();
        test_move_right();
        test_reverse();
        test_grow();
        test_wall();
        test_self();
        test_pixel();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
